// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package dmem_pkg;

  localparam int WORD_W    = 32;
  localparam int BE_W      = WORD_W / 8;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage with a byte-enabled synchronous write port and a registered read port.
// Contents are intentionally not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_rd_en) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: valid/ready request, fixed-latency access, valid/ready response.
// Define DMEM_ERR_EN to flag misaligned / out-of-range requests instead of wrapping them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam bit LAT_ONE = (LATENCY == 1);

  state_t               r_state;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic                 r_we;
  logic [IDX_W-1:0]     r_idx;
  logic [WORD_W-1:0]    r_wdata;
  logic [BE_W-1:0]      r_be;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_fire;
  logic                 w_use_in;
  logic                 w_we;
  logic [IDX_W-1:0]     w_idx;
  logic [WORD_W-1:0]    w_wdata;
  logic [BE_W-1:0]      w_be;
  logic                 w_err_in;
  logic                 w_err;
  logic [WORD_W-1:0]    w_rd;

`ifdef DMEM_ERR_EN
  assign w_err_in = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:IDX_W+2] != '0);
`else
  logic w_unused_addr;
  assign w_err_in      = 1'b0;
  assign w_unused_addr = ^{req_addr_i[31:IDX_W+2], req_addr_i[1:0]};
`endif

  assign w_accept = (r_state == ST_IDLE) && req_valid_i;
  // With LATENCY==1 the access happens on the accept edge straight from the inputs.
  assign w_fire   = (w_accept && LAT_ONE) ||
                    ((r_state == ST_WAIT) && (r_cnt == LAT_CNT_W'(1)));
  assign w_use_in = (r_state == ST_IDLE);
  assign w_we     = w_use_in ? req_we_i                 : r_we;
  assign w_idx    = w_use_in ? req_addr_i[IDX_W+1:2]    : r_idx;
  assign w_wdata  = w_use_in ? req_wdata_i              : r_wdata;
  assign w_be     = w_use_in ? req_be_i                 : r_be;
  assign w_err    = w_use_in ? w_err_in                 : r_err;

  // rst_i gates the write so a store caught by reset is never committed.
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .i_clk   (clk_i),
    .i_wr_en (w_fire && w_we && !w_err && rst_i),
    .i_rd_en (w_fire && !w_we && !w_err),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .i_be    (w_be),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid_i) begin
          r_we    <= req_we_i;
          r_idx   <= req_addr_i[IDX_W+1:2];
          r_wdata <= req_wdata_i;
          r_be    <= req_be_i;
          r_err   <= w_err_in;
          r_cnt   <= LAT_CNT_W'(LATENCY - 1);
          r_state <= LAT_ONE ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - LAT_CNT_W'(1);
          if (r_cnt == LAT_CNT_W'(1)) r_state <= ST_RESP;
        end
        ST_RESP: if (rsp_ready_i) begin
          r_state <= ST_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign rsp_valid_o = (r_state == ST_RESP);
  assign rsp_err_o   = (r_state == ST_RESP) && r_err;
  assign rsp_rdata_o = ((r_state == ST_RESP) && !r_we && !r_err) ? w_rd : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: u_dut runs LATENCY=2, u_dut1 runs LATENCY=1 for back-to-back spacing.
module tb_dmem_responder;

`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_be = '0;
  logic        b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_err, b_busy;
  logic [31:0] b_rsp_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .busy_o(busy)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
    .rsp_err_o(b_rsp_err), .busy_o(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called just after a rising edge with u_dut idle. lat counts cycles from the
  // request cycle (cycle 0) to the first cycle showing rsp_valid.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err,
                      output int lat);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    // scramble inputs: only the accept edge may matter
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC;
    req_wdata = 32'h5A5A_5A5A; req_be = 4'hF;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rdata = rsp_rdata; err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    // 1: reset state, then a store dropped by reset mid-WAIT
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   {31'd0, rsp_err}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    rst = 1'b1;
    xact(1'b1, 32'h10, 32'h0102_0304, 4'hF, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_err",   {31'd0, rsp_err}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    rst = 1'b1;
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("dropped_store", rd, 32'h0102_0304);

    // 2: full store and load, latency
    xact(1'b1, 32'h40, 32'h1234_5678, 4'hF, rd, er, lat);
    chk("st_lat", lat, 32'd2);
    chk("st_rdata", rd, 32'd0);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("ld_lat", lat, 32'd2);
    chk("ld_rdata", rd, 32'h1234_5678);

    // 3: partial store, plus be=0 store that must change nothing
    xact(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    xact(1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    chk("be0_lat", lat, 32'd2);
    xact(1'b0, 32'h41, 32'h0, 4'h0, rd, er, lat);
    chk("partial", rd, 32'h12BB_56DD);

    // 4: backpressure with a competing request held on the input
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h12BB_56DD);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_busy",  {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("take_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("next_accept", {31'd0, busy}, 32'd1);
    begin
      int t = 0;
      while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
      chk("bp_st_done", {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("bp_kept", rd, 32'h12BB_56DD);
    xact(1'b0, 32'h80, 32'h0, 4'h0, rd, er, lat);
    chk("bp_store", rd, 32'h55);

    // 5: wrap / error behaviour
    xact(1'b1, 32'h0, 32'h77, 4'hF, rd, er, lat);
    xact(1'b1, 32'h1000, 32'h11, 4'hF, rd, er, lat);
    chk("oob_st_err", {31'd0, er}, {31'd0, ERR_EN});
    chk("oob_st_lat", lat, 32'd2);
    xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("wrap_ld", rd, ERR_EN ? 32'h77 : 32'h11);
    xact(1'b0, 32'h42, 32'h0, 4'h0, rd, er, lat);
    chk("mis_err", {31'd0, er}, {31'd0, ERR_EN});
    chk("mis_rdata", rd, ERR_EN ? 32'h0 : 32'h12BB_56DD);
    chk("err_clear", {31'd0, rsp_err}, 32'd0);

    // 6: LATENCY=1 back-to-back with rsp_ready held high
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'hBEEF; b_req_be = 4'hF;
    @(posedge clk); #1;
    chk("b_rsp1", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_st_rdata", b_rsp_rdata, 32'd0);
    b_req_we = 1'b0;
    @(posedge clk); #1;
    chk("b_gap1", {31'd0, b_rsp_valid}, 32'd0);
    chk("b_ready1", {31'd0, b_req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("b_rsp2", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_ld_rdata", b_rsp_rdata, 32'hBEEF);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("b_alt", {31'd0, b_rsp_valid}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    b_req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
